bcd_counter_multi: RTL and testbench
====================================

# bcd_counter_multi

Parametrised multi-digit synchronous BCD counter: DIGITS decades, up/down counting, synchronous parallel load with digit validation, and wrap or saturate at the range ends. It replaces chains of single-decade counters in display and timing paths. All decades update in the same cycle, with no ripple latency between digits. A cascade output lets wider counters be built from several instances.

## Interface
- DIGITS, 4: number of BCD decades, 1..8.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the terminal value.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  count enable; one count step per cycle while high.
- up_dn  in  1  count direction: 1 = up, 0 = down; sampled with clk_en.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  load value; digit i occupies bits [4i+3:4i].
- sal  out  4*DIGITS  counter value, same digit packing as load_val.
- tc  out  1  terminal count (combinational): clk_en & (up_dn ? all digits 9 : all digits 0).
- ovf  out  1  sticky flag: a wrap, or a saturated attempt to step past a range end, has occurred.
- load_err  out  1  registered one-cycle pulse: the last load contained at least one digit > 9.

## Operation
- Update priority each edge: rst > load > clk_en count > hold.
- rst: sal = 0, ovf = 0, load_err = 0.
- load: each digit of load_val that is ≤ 9 is loaded unchanged.
  - Any digit > 9 is loaded as 0.
  - load_err = 1 for that one cycle if any digit was invalid; otherwise 0.
  - ovf is cleared.
  - clk_en is ignored in the same cycle.
- Count up, digit i steps when clk_en = 1 and every lower digit is 9:
  - digit 9 → 0;
  - any other digit → d + 1.
- Count down, digit i steps when clk_en = 1 and every lower digit is 0:
  - digit 0 → 9;
  - any other digit → d − 1.
- Digit 0 steps on every enabled cycle.
- Range ends: up from all-9s, or down from all-0s.
  - SATURATE = 0: the value wraps to all-0s (up) or all-9s (down); ovf is set.
  - SATURATE = 1: the value holds; ovf is set.
- load_err returns to 0 on the first cycle without an invalid load.
- ovf remains set until rst or load.
- tc is purely combinational from the current state and inputs, so the next instance's clk_en can be driven directly from it.
- Stored digits are always ≤ 9. No input sequence produces a non-BCD digit.

## Timing
- Latency: sal reflects a load or count step one cycle after the sampling edge.
- Carry and borrow are resolved combinationally across all DIGITS within one cycle.
  - Longest path: DIGITS-deep all-9 / all-0 detection.
- up_dn may change on any cycle; it takes effect on the next enabled edge.
- Reset applied mid-count, or in the same cycle as load: the reset values win, and the load is discarded.
- load and clk_en high in the same cycle: the load value is taken, and no step is applied to it.
- tc is valid in the same cycle as the state it describes. It is not registered.

## Structure
- Package bcd_pkg holds:
  - BCD_W = 4;
  - BCD_MAX = 4'd9;
  - function bcd_valid(d) returning d ≤ 9.
- Sub-module bcd_digit, one instance per decade:
  - inputs: clk, rst, step, up_dn, load, load_d;
  - outputs: q, at_max (q == 9), at_min (q == 0).
- The top level generates:
  - the prefix AND chains of at_max / at_min that form each digit's step;
  - the range-end detection, the saturate gating, and the ovf / load_err registers.

## Test plan
All scenarios use DIGITS = 4 unless a parameter value is given.
1. Reset, then 1234 enabled up cycles → sal = 16'h1234, ovf = 0; tc = 0 throughout.
2. Load 16'h0999 with up_dn = 1, one enabled cycle → 16'h1000. Set up_dn = 0, one enabled cycle → 16'h0999.
3. SATURATE = 0: load 16'h9999, clk_en = 1, up_dn = 1.
   - tc = 1 before the edge.
   - Next cycle: sal = 16'h0000, ovf = 1.
   - Down from 16'h0000 → 16'h9999.
4. SATURATE = 1: load 16'h0000, 3 enabled down cycles → sal stays 16'h0000, ovf = 1. A following load of 16'h0005 clears ovf.
5. Load 16'h1A3F → sal = 16'h1030; load_err = 1 for exactly one cycle.
6. Raise rst together with load = 1 and clk_en = 1 → sal = 0, ovf = 0, load_err = 0 on the next cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit validity helper used by the counter slice.
package bcd_pkg;

   localparam int          BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   // True when a nibble holds a legal decimal digit (0..9).
   function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, steps up or down by one, and flags its 9 / 0 states
// so the top level can build carry and borrow chains without ripple registers.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             up_dn,
   input  logic             load,
   input  logic [BCD_W-1:0] load_d,
   output logic [BCD_W-1:0] q,
   output logic             at_max,
   output logic             at_min
);

   assign at_max = (q == BCD_MAX);
   assign at_min = (q == '0);

   // Digit register: reset beats load beats step; an illegal load nibble becomes 0
   // so the stored value can never leave the 0..9 range.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= bcd_valid(load_d) ? load_d : '0;
      end else if (step) begin
         if (up_dn) begin
            q <= at_max ? '0 : q + 4'd1;
         end else begin
            q <= at_min ? BCD_MAX : q - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-decade synchronous BCD counter. Every decade updates on the same edge:
// each digit's step comes from a combinational prefix-AND of the lower digits'
// 9 (up) or 0 (down) flags. The range end can wrap or saturate, and tc is left
// combinational so it can feed the next instance's clk_en directly.
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   sal,
   output logic                  tc,
   output logic                  ovf,
   output logic                  load_err
);

   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_min;
   logic [DIGITS-1:0] step;
   logic [DIGITS:0]   max_chain;
   logic [DIGITS:0]   min_chain;
   logic              range_end;
   logic              sat_hold;
   logic              load_bad;

   // Chain element i is high when every digit below i is 9 (or 0); digit 0
   // therefore always sees a true chain and steps on every enabled cycle.
   assign max_chain[0] = 1'b1;
   assign min_chain[0] = 1'b1;

   // The whole counter sits at the end of its range in the current direction.
   assign range_end = clk_en & (up_dn ? max_chain[DIGITS] : min_chain[DIGITS]);
   assign tc        = range_end;

   // In saturate mode the terminal step is suppressed for every digit at once.
   assign sat_hold  = SATURATE & range_end;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign max_chain[gi+1] = max_chain[gi] & at_max[gi];
      assign min_chain[gi+1] = min_chain[gi] & at_min[gi];
      assign step[gi] = clk_en & ~sat_hold & (up_dn ? max_chain[gi] : min_chain[gi]);

      bcd_digit u_digit (
         .clk    (clk),
         .rst    (rst),
         .step   (step[gi]),
         .up_dn  (up_dn),
         .load   (load),
         .load_d (load_val[BCD_W*gi +: BCD_W]),
         .q      (sal[BCD_W*gi +: BCD_W]),
         .at_max (at_max[gi]),
         .at_min (at_min[gi])
      );
   end

   // Flag a load that carries any non-decimal nibble.
   always_comb begin
      load_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_valid(load_val[BCD_W*i +: BCD_W])) begin
            load_bad = 1'b1;
         end
      end
   end

   // Status registers: ovf is sticky until reset or load, load_err is a
   // single-cycle pulse following a load with an illegal digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf      <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         ovf      <= 1'b0;
         load_err <= load_bad;
      end else begin
         load_err <= 1'b0;
         if (range_end) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench for bcd_counter_multi: a wrapping and a saturating instance
// share the same stimulus; expected values are queued as stimulus is issued and
// a negedge monitor pops and compares them against the selected instance.
module tb_bcd_counter_multi;

   localparam int DIGITS = 4;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic        up_dn;
   logic        load;
   logic [15:0] load_val;

   logic [15:0] sal_w, sal_s;
   logic        tc_w, tc_s, ovf_w, ovf_s, lerr_w, lerr_s;

   typedef struct packed {
      logic        sat;
      logic [3:0]  mask;
      logic [15:0] sal;
      logic        ovf;
      logic        lerr;
      logic        tc;
   } exp_t;

   exp_t  expQ[$];
   string nameQ[$];
   int    vectors = 0;
   int    miscompares = 0;

   bcd_counter_multi #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .sal(sal_w), .tc(tc_w), .ovf(ovf_w), .load_err(lerr_w)
   );

   bcd_counter_multi #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .sal(sal_s), .tc(tc_s), .ovf(ovf_s), .load_err(lerr_s)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on each falling edge drain every queued expectation.
   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         exp_t        e;
         string       nm;
         logic [15:0] s;
         logic        o, le, t;
         e  = expQ.pop_front();
         nm = nameQ.pop_front();
         s  = e.sat ? sal_s  : sal_w;
         o  = e.sat ? ovf_s  : ovf_w;
         le = e.sat ? lerr_s : lerr_w;
         t  = e.sat ? tc_s   : tc_w;
         if (e.mask[0]) begin
            vectors++;
            if (s !== e.sal) begin
               miscompares++;
               $display("[TB] FAIL %s sat=%0d sal got %h expected %h", nm, e.sat, s, e.sal);
            end
         end
         if (e.mask[1]) begin
            vectors++;
            if (o !== e.ovf) begin
               miscompares++;
               $display("[TB] FAIL %s sat=%0d ovf got %b expected %b", nm, e.sat, o, e.ovf);
            end
         end
         if (e.mask[2]) begin
            vectors++;
            if (le !== e.lerr) begin
               miscompares++;
               $display("[TB] FAIL %s sat=%0d load_err got %b expected %b", nm, e.sat, le, e.lerr);
            end
         end
         if (e.mask[3]) begin
            vectors++;
            if (t !== e.tc) begin
               miscompares++;
               $display("[TB] FAIL %s sat=%0d tc got %b expected %b", nm, e.sat, t, e.tc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic en, input logic ud,
                                input logic ld, input logic [15:0] lv);
      rst      = r;
      clk_en   = en;
      up_dn    = ud;
      load     = ld;
      load_val = lv;
   endtask

   // mask bits: 0 sal, 1 ovf, 2 load_err, 3 tc
   task automatic checkOutput(input string nm, input logic sat, input logic [3:0] mask,
                              input logic [15:0] s, input logic o, input logic le,
                              input logic t);
      exp_t e;
      e.sat = sat; e.mask = mask; e.sal = s; e.ovf = o; e.lerr = le; e.tc = t;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("reset_w", 1'b0, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_s", 1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0);

      // 1234 enabled up steps from zero, tc must never rise
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 1234; i++) begin
         checkOutput("count_tc", 1'b0, 4'h8, 16'h0000, 1'b0, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("count_1234_w", 1'b0, 4'h3, 16'h1234, 1'b0, 1'b0, 1'b0);
      checkOutput("count_1234_s", 1'b1, 4'h3, 16'h1234, 1'b0, 1'b0, 1'b0);

      // load 0999 with clk_en high: load wins, no step
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0999);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput("load_0999", 1'b0, 4'hF, 16'h0999, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("carry_1000", 1'b0, 4'h1, 16'h1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("borrow_0999", 1'b0, 4'h3, 16'h0999, 1'b0, 1'b0, 1'b0);

      // up from all nines
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput("top_tc_w", 1'b0, 4'hB, 16'h9999, 1'b0, 1'b0, 1'b1);
      checkOutput("top_tc_s", 1'b1, 4'hB, 16'h9999, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("wrap_up_w", 1'b0, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_up_s", 1'b1, 4'h3, 16'h9999, 1'b1, 1'b0, 1'b0);

      // down from all zeros (wrap instance) / from 9999 (saturating instance)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("bot_tc_w", 1'b0, 4'h8, 16'h0000, 1'b0, 1'b0, 1'b1);
      checkOutput("bot_tc_s", 1'b1, 4'h8, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("wrap_dn_w", 1'b0, 4'h3, 16'h9999, 1'b1, 1'b0, 1'b0);
      checkOutput("step_dn_s", 1'b1, 4'h3, 16'h9998, 1'b1, 1'b0, 1'b0);

      // saturate at zero for three down cycles
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("load_clr_w", 1'b0, 4'hB, 16'h0000, 1'b0, 1'b0, 1'b1);
      checkOutput("load_clr_s", 1'b1, 4'hB, 16'h0000, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("sat_dn_s", 1'b1, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("wrap_dn3_w", 1'b0, 4'h3, 16'h9997, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("load5_s", 1'b1, 4'h7, 16'h0005, 1'b0, 1'b0, 1'b0);
      checkOutput("load5_w", 1'b0, 4'h7, 16'h0005, 1'b0, 1'b0, 1'b0);

      // invalid digits load as zero, load_err pulses once
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1A3F);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("bad_load_w", 1'b0, 4'h5, 16'h1030, 1'b0, 1'b1, 1'b0);
      checkOutput("bad_load_s", 1'b1, 4'h5, 16'h1030, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("lerr_drop_w", 1'b0, 4'h5, 16'h1030, 1'b0, 1'b0, 1'b0);

      // reset beats a simultaneous load and count
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h1A3F);
      checkOutput("pre_rst_ovf", 1'b1, 4'h3, 16'h9999, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("rst_win_w", 1'b0, 4'h7, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_win_s", 1'b1, 4'h7, 16'h0000, 1'b0, 1'b0, 1'b0);

      // bounded drain of the scoreboard
      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge clk);
      end
      if (expQ.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain pending got %0d expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
